conv_job_sequencer: RTL and testbench
=====================================

// Module: conv_job_sequencer
// PURPOSE
//  Queues convolution jobs from the host and runs the binary 3x3 XNOR-conv engine on them
//  one at a time, using the engine's dut_run/dut_busy handshake. Sits between the host
//  control port and the conv engine.
//  - Drives the engine's weight-select.
//  - Reports per-job completion with a tag and an error flag.
//  - Keeps a completed-job count.
// PARAMETERS
//  DEPTH     4    job FIFO entries (power of two, >=2)
//  WSEL_W    4    weight-select width (engine weight-memory word index)
//  TAG_W     4    host job tag width
//  TMO_CYC   4096 watchdog limit in cycles (used only with CONV_SEQ_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  reset_b    in   1       asynchronous, active-low reset
//  job_valid  in   1       host offers a job
//  job_ready  out  1       FIFO not full; job accepted on a clock edge where valid&ready
//  job_wsel   in   WSEL_W  weight select for the offered job
//  job_tag    in   TAG_W   tag returned on completion
//  eng_run    out  1       one-cycle start pulse to the engine (drives its dut_run)
//  eng_wsel   out  WSEL_W  weight select to the engine; held stable for the whole job
//  eng_busy   in   1       engine dut_busy
//  done_valid out  1       one-cycle completion pulse
//  done_tag   out  TAG_W   tag of the completed job; valid while done_valid=1
//  done_err   out  1       1 = job aborted by watchdog; valid while done_valid=1
//  seq_busy   out  1       1 when the FIFO is non-empty or the FSM is not in S_IDLE
//  jobs_done  out  16      completed-job count; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values
//  - All outputs 0, except job_ready=1. FIFO empty. FSM in S_IDLE.
//  - Reset asserted mid-job discards queued jobs and the job in flight.
//  - No done pulse is issued for discarded jobs, and eng_run is low immediately.
//  FIFO
//  - Push when job_valid & job_ready. Pop when the FSM leaves S_IDLE.
//  - job_ready = !full. It is not qualified by a same-cycle pop, so a full FIFO refuses
//    a push even in a pop cycle.
//  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//  FSM states, one-hot, all outputs registered
//  - S_IDLE: go to S_LAUNCH when FIFO non-empty & !eng_busy. A stray eng_busy=1 holds
//    the FSM in S_IDLE. On exit, pop the head entry and latch wsel/tag.
//  - S_LAUNCH: eng_run=1 for exactly this one cycle; eng_wsel already valid. Go to S_ACK.
//  - S_ACK: wait for eng_busy=1, then go to S_DONE.
//  - S_DONE: wait for eng_busy=0, then go to S_REPORT.
//  - S_REPORT: done_valid=1 for one cycle; jobs_done increments unless saturated.
//    Go to S_IDLE.
//  Latency
//  - Job accepted at edge N into an empty FIFO with the engine idle: eng_run is high in
//    the cycle after edge N+2.
//  - done_valid goes high 2 cycles after the edge where eng_busy is sampled low.
//  - Back-to-back jobs have at least 1 S_IDLE cycle between done_valid and the next
//    eng_run.
//  Other rules
//  - eng_busy is ignored while in S_LAUNCH. The engine's busy rises one cycle after its
//    run input.
//  - A push and the FSM pop in the same cycle are both honoured; the count is unchanged.
//  - eng_wsel keeps its last value between jobs.
//  - seq_busy is registered.
// CONFIGURATION
//  CONV_SEQ_TIMEOUT_EN defined:
//  - A 16-bit watchdog clears on entry to S_ACK and counts in S_ACK and S_DONE.
//  - When it reaches TMO_CYC-1 the FSM goes to S_REPORT with done_err=1.
//  - jobs_done still increments.
//  - Before the next launch the FSM waits in S_IDLE until eng_busy=0.
//  CONV_SEQ_TIMEOUT_EN undefined:
//  - No watchdog logic; S_ACK and S_DONE wait indefinitely.
//  - done_err is tied to 0.
// TESTING
//  1. Single job: push wsel=1, tag=5; engine model raises busy 1 cycle after run and
//     drops it 40 cycles later -> exactly one eng_run pulse, eng_wsel=1 throughout,
//     done_valid with tag=5 and err=0, jobs_done=1.
//  2. Fill: push 5 jobs back-to-back with DEPTH=4 while the engine is busy -> job_ready=0
//     after the 4th accept. The 5th is taken once a slot frees. Tags complete in order
//     0..4, with no lost or duplicated eng_run.
//  3. Stray busy: hold eng_busy=1 before any push, then push a job -> no eng_run until
//     busy=0; then run 3 cycles later.
//  4. Reset mid-job: assert reset_b=0 in S_DONE with 2 jobs queued -> all outputs reset
//     and no done_valid. After release, seq_busy=0 and job_ready=1.
//  5. Timeout (CONV_SEQ_TIMEOUT_EN, TMO_CYC=16): engine never raises busy -> done_valid
//     with err=1 16 cycles after entering S_ACK; next queued job then runs normally.
//  6. Saturation: preload jobs_done to 16'hFFFE via force, then run 3 jobs -> reads
//     16'hFFFF and stays there.

Source files
------------

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: queues host conv jobs and runs them one at a time on the XNOR-conv
// engine over its run/busy handshake. Define CONV_SEQ_TIMEOUT_EN to add the watchdog abort.
module conv_job_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WSEL_W  = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [WSEL_W-1:0] job_wsel,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              eng_run,
  output logic [WSEL_W-1:0] eng_wsel,
  input  logic              eng_busy,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic              done_err,
  output logic              seq_busy,
  output logic [15:0]       jobs_done
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = WSEL_W + TAG_W;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LAUNCH = 5'b00010,
    S_ACK    = 5'b00100,
    S_DONE   = 5'b01000,
    S_REPORT = 5'b10000
  } state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              full, empty, push, pop, timeout;
  logic              nonempty_q, busy_s1_q, busy_s2_q, seq_busy_q;
  logic              eng_run_q, done_valid_q, done_err_q;
  logic [WSEL_W-1:0] eng_wsel_q;
  logic [TAG_W-1:0]  tag_q;
  logic [15:0]       jobs_done_q;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = job_valid && !full;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

`ifdef CONV_SEQ_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;

  always_comb begin
    wd_d    = wd_q;
    timeout = 1'b0;
    if (state_q == S_LAUNCH) begin
      wd_d = '0;
    end else if (state_q == S_ACK || state_q == S_DONE) begin
      if (wd_q == 16'(TMO_CYC - 1)) timeout = 1'b1;
      else                          wd_d    = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign timeout    = 1'b0;
`endif

  // Launch decisions use the registered non-empty flag and a two-stage busy sample,
  // which sets the accept-to-run and busy-low-to-done latencies.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nonempty_q && !empty && !busy_s2_q) begin
          state_d = S_LAUNCH;
          pop     = 1'b1;
        end
      end
      S_LAUNCH: state_d = S_ACK;
      S_ACK:    if (busy_s2_q)  state_d = S_DONE;
      S_DONE:   if (!busy_s2_q) state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_REPORT;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {job_wsel, job_tag};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      nonempty_q   <= 1'b0;
      busy_s1_q    <= 1'b0;
      busy_s2_q    <= 1'b0;
      seq_busy_q   <= 1'b0;
      eng_run_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      eng_wsel_q   <= '0;
      tag_q        <= '0;
      jobs_done_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      nonempty_q   <= !empty;
      busy_s1_q    <= eng_busy;
      busy_s2_q    <= busy_s1_q;
      seq_busy_q   <= (wr_ptr_d != rd_ptr_d) || (state_d != S_IDLE);
      eng_run_q    <= (state_d == S_LAUNCH);
      done_valid_q <= (state_d == S_REPORT);
      done_err_q   <= timeout;
      if (pop) {eng_wsel_q, tag_q} <= mem_q[rd_ptr_q[AW-1:0]];
      if (state_d == S_REPORT && jobs_done_q != '1) jobs_done_q <= jobs_done_q + 16'd1;
    end
  end

  assign job_ready  = !full;
  assign eng_run    = eng_run_q;
  assign eng_wsel   = eng_wsel_q;
  assign done_valid = done_valid_q;
  assign done_tag   = tag_q;
  assign done_err   = done_err_q;
  assign seq_busy   = seq_busy_q;
  assign jobs_done  = jobs_done_q;
endmodule

// File: tb/tb_conv_job_sequencer.sv
// Self-checking bench for conv_job_sequencer: engine model, event logs and an in-order job model.
module tb_conv_job_sequencer;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [3:0]  job_wsel = '0, job_tag = '0;
  logic        eng_run, eng_busy, done_valid, done_err, seq_busy;
  logic [3:0]  eng_wsel, done_tag;
  logic [15:0] jobs_done;

  int total = 0, bad = 0, cyc = 0;
  logic busy_m = 1'b0, busy_force = 1'b0, eng_dead = 1'b0;
  int busy_len = 40, eng_cnt = 0;

  int         run_c[$];
  logic [3:0] run_w[$];
  int         done_c[$];
  logic [3:0] done_t[$], done_w[$];
  logic       done_e[$];
  logic [15:0] done_j[$];
  logic [3:0] exp_w[$], exp_t[$];
  int exp_jobs = 0;

  conv_job_sequencer #(.DEPTH(4), .WSEL_W(4), .TAG_W(4), .TMO_CYC(16)) dut (
    .clk(clk), .reset_b(reset_b), .job_valid(job_valid), .job_ready(job_ready),
    .job_wsel(job_wsel), .job_tag(job_tag), .eng_run(eng_run), .eng_wsel(eng_wsel),
    .eng_busy(eng_busy), .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err),
    .seq_busy(seq_busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Engine: busy rises the cycle after run and stays high for busy_len cycles.
  assign eng_busy = busy_m | busy_force;
  always @(posedge clk) begin
    if (!reset_b) begin
      busy_m <= 1'b0; eng_cnt <= 0;
    end else if (eng_run && !eng_dead) begin
      busy_m <= 1'b1; eng_cnt <= busy_len - 1;
    end else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    else busy_m <= 1'b0;
  end

  always @(negedge clk) begin
    if (eng_run) begin run_c.push_back(cyc); run_w.push_back(eng_wsel); end
    if (done_valid) begin
      done_c.push_back(cyc); done_t.push_back(done_tag); done_w.push_back(eng_wsel);
      done_e.push_back(done_err); done_j.push_back(jobs_done);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_logs();
    run_c.delete(); run_w.delete(); done_c.delete(); done_t.delete();
    done_w.delete(); done_e.delete(); done_j.delete();
  endtask

  task automatic push_job(input logic [3:0] w, input logic [3:0] t, output int acc, output bit ok);
    int n = 0;
    job_valid = 1'b1; job_wsel = w; job_tag = t;
    while (!job_ready && n < 3000) begin step(); n++; end
    ok = job_ready;
    acc = -1;
    if (ok) begin
      step(); acc = cyc;
      exp_w.push_back(w); exp_t.push_back(t);
    end
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int limit, output bit ok);
    int k = 0;
    while (done_t.size() < n && k < limit) begin step(); k++; end
    ok = (done_t.size() >= n);
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL rst_job_ready got=%0b want=1", job_ready); end
    total++; if (eng_run !== 1'b0) begin bad++; $display("FAIL rst_eng_run got=%0b want=0", eng_run); end
    total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL rst_done_valid got=%0b want=0", done_valid); end
    total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL rst_seq_busy got=%0b want=0", seq_busy); end
    total++; if (jobs_done !== 16'h0) begin bad++; $display("FAIL rst_jobs_done got=%h want=0", jobs_done); end
    total++; if ({eng_wsel, done_tag, done_err} !== 9'h0) begin bad++; $display("FAIL rst_misc got=%h want=0", {eng_wsel, done_tag, done_err}); end
    reset_b = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single();
    int acc; bit ok;
    clear_logs(); busy_len = 40;
    push_job(4'd1, 4'd5, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_accept got=0 want=1"); end
    wait_done(1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=0 want=1"); end
    repeat (5) step();
    exp_jobs++;
    total++; if (run_c.size() != 1) begin bad++; $display("FAIL single_run_count got=%0d want=1", run_c.size()); end
    total++; if (run_c[0] != acc + 2) begin bad++; $display("FAIL single_run_latency got=%0d want=%0d", run_c[0], acc + 2); end
    total++; if (run_w[0] !== exp_w[0] || done_w[0] !== exp_w[0]) begin bad++; $display("FAIL single_wsel got=%h/%h want=%h", run_w[0], done_w[0], exp_w[0]); end
    total++; if (done_t[0] !== exp_t[0] || done_e[0] !== 1'b0) begin bad++; $display("FAIL single_tag_err got=%h/%b want=%h/0", done_t[0], done_e[0], exp_t[0]); end
    total++; if (done_c[0] != run_c[0] + 44) begin bad++; $display("FAIL single_done_latency got=%0d want=%0d", done_c[0], run_c[0] + 44); end
    total++; if (done_j[0] !== 16'(exp_jobs) || done_t.size() != 1) begin bad++; $display("FAIL single_jobs_done got=%h want=%h", done_j[0], 16'(exp_jobs)); end
    total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL single_seq_busy_idle got=%b want=0", seq_busy); end
    exp_w.delete(); exp_t.delete();
  endtask

  task automatic test_fill();
    int acc, c, nok; bit ok;
    clear_logs(); busy_len = 10 + int'($urandom_range(0, 20));
    busy_force = 1'b1; repeat (4) step();
    nok = 0;
    for (int i = 0; i < 4; i++) begin
      push_job(4'($urandom_range(0, 15)), 4'(i), acc, ok);
      if (ok) nok++;
    end
    total++; if (nok != 4) begin bad++; $display("FAIL fill_accepts got=%0d want=4", nok); end
    total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_full got=%b want=0", job_ready); end
    c = cyc; busy_force = 1'b0;
    push_job(4'($urandom_range(0, 15)), 4'd4, acc, ok);
    total++; if (acc != c + 4) begin bad++; $display("FAIL fill_fifth_accept got=%0d want=%0d", acc, c + 4); end
    wait_done(5, 5 * (busy_len + 20) + 50, ok);
    total++; if (!ok || run_c.size() != 5) begin bad++; $display("FAIL fill_counts got=%0d/%0d want=5/5", run_c.size(), done_t.size()); end
    for (int i = 0; i < 5 && i < done_t.size(); i++) begin
      total++;
      if (run_w[i] !== exp_w[i] || done_t[i] !== exp_t[i] || done_e[i] !== 1'b0 || done_j[i] !== 16'(exp_jobs + i + 1)) begin
        bad++; $display("FAIL fill_job%0d got=w%h t%h e%b n%h want=w%h t%h e0 n%h", i, run_w[i], done_t[i], done_e[i], done_j[i], exp_w[i], exp_t[i], 16'(exp_jobs + i + 1));
      end
      if (i > 0) begin
        total++; if (run_c[i] < done_c[i-1] + 2) begin bad++; $display("FAIL fill_gap%0d got=%0d want>=%0d", i, run_c[i], done_c[i-1] + 2); end
      end
    end
    exp_jobs += 5; exp_w.delete(); exp_t.delete();
    repeat (5) step();
  endtask

  task automatic test_stray_busy();
    int acc, c, k; bit ok;
    clear_logs(); busy_len = 8;
    busy_force = 1'b1; repeat (3) step();
    push_job(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc, ok);
    repeat (10) step();
    total++; if (run_c.size() != 0) begin bad++; $display("FAIL stray_no_run got=%0d want=0", run_c.size()); end
    c = cyc; busy_force = 1'b0; k = 0;
    while (run_c.size() == 0 && k < 20) begin step(); k++; end
    total++; if (run_c.size() != 1 || run_c[0] != c + 3) begin bad++; $display("FAIL stray_run_cycle got=%0d want=%0d", run_c[0], c + 3); end
    wait_done(1, 100, ok);
    exp_jobs++;
    total++; if (!ok || done_t[0] !== exp_t[0] || done_j[0] !== 16'(exp_jobs)) begin bad++; $display("FAIL stray_done got=t%h n%h want=t%h n%h", done_t[0], done_j[0], exp_t[0], 16'(exp_jobs)); end
    exp_w.delete(); exp_t.delete();
    repeat (5) step();
  endtask

  task automatic test_random();
    int acc; bit ok;
    clear_logs(); busy_len = int'($urandom_range(1, 30));
    for (int i = 0; i < 12; i++) begin
      push_job(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc, ok);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_done(12, 12 * (busy_len + 12) + 100, ok);
    repeat (3) step();
    total++; if (!ok || run_c.size() != 12) begin bad++; $display("FAIL rand_counts got=%0d/%0d want=12/12", run_c.size(), done_t.size()); end
    for (int i = 0; i < 12 && i < done_t.size(); i++) begin
      total++;
      if (run_w[i] !== exp_w[i] || done_t[i] !== exp_t[i] || done_w[i] !== exp_w[i] || done_e[i] !== 1'b0) begin
        bad++; $display("FAIL rand_job%0d got=w%h t%h e%b want=w%h t%h e0", i, run_w[i], done_t[i], done_e[i], exp_w[i], exp_t[i]);
      end
      total++;
      if (done_c[i] != run_c[i] + busy_len + 4 || done_j[i] !== 16'(exp_jobs + i + 1)) begin
        bad++; $display("FAIL rand_timing%0d got=c%0d n%h want=c%0d n%h", i, done_c[i], done_j[i], run_c[i] + busy_len + 4, 16'(exp_jobs + i + 1));
      end
    end
    exp_jobs += 12; exp_w.delete(); exp_t.delete();
    repeat (5) step();
  endtask

`ifdef CONV_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int acc; bit ok;
    clear_logs(); busy_len = 6; eng_dead = 1'b1;
    push_job(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc, ok);
    push_job(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc, ok);
    wait_done(1, 200, ok);
    eng_dead = 1'b0;
    total++; if (!ok || done_e[0] !== 1'b1 || done_t[0] !== exp_t[0]) begin bad++; $display("FAIL tmo_abort got=e%b t%h want=e1 t%h", done_e[0], done_t[0], exp_t[0]); end
    total++; if (done_c[0] != run_c[0] + 17) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", done_c[0], run_c[0] + 17); end
    wait_done(2, 200, ok);
    total++; if (!ok || done_e[1] !== 1'b0 || done_t[1] !== exp_t[1] || run_w[1] !== exp_w[1]) begin bad++; $display("FAIL tmo_next_job got=e%b t%h w%h want=e0 t%h w%h", done_e[1], done_t[1], run_w[1], exp_t[1], exp_w[1]); end
    total++; if (done_j[1] !== 16'(exp_jobs + 2)) begin bad++; $display("FAIL tmo_jobs_done got=%h want=%h", done_j[1], 16'(exp_jobs + 2)); end
    exp_jobs += 2; exp_w.delete(); exp_t.delete();
    repeat (5) step();
  endtask
`endif

  task automatic test_reset_mid();
    int acc, k, nd, nr; bit ok;
    clear_logs(); busy_len = 100;
    for (int i = 0; i < 3; i++) push_job(4'($urandom_range(1, 15)), 4'(i), acc, ok);
    k = 0;
    while (run_c.size() == 0 && k < 50) begin step(); k++; end
    repeat (20) step();
    total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", seq_busy); end
    reset_b = 1'b0; #1;
    total++; if (eng_run !== 1'b0 || done_valid !== 1'b0 || seq_busy !== 1'b0 || job_ready !== 1'b1) begin bad++; $display("FAIL rmid_outputs got=%b%b%b%b want=0001", eng_run, done_valid, seq_busy, job_ready); end
    total++; if (jobs_done !== 16'h0 || eng_wsel !== 4'h0 || done_tag !== 4'h0) begin bad++; $display("FAIL rmid_values got=%h/%h/%h want=0/0/0", jobs_done, eng_wsel, done_tag); end
    repeat (3) step();
    reset_b = 1'b1; exp_jobs = 0; exp_w.delete(); exp_t.delete();
    nd = done_t.size(); nr = run_c.size();
    repeat (150) step();
    total++; if (done_t.size() != nd || run_c.size() != nr) begin bad++; $display("FAIL rmid_discard got=%0d/%0d want=%0d/%0d", done_t.size(), run_c.size(), nd, nr); end
    total++; if (seq_busy !== 1'b0 || job_ready !== 1'b1) begin bad++; $display("FAIL rmid_after got=%b%b want=01", seq_busy, job_ready); end
  endtask

  task automatic test_saturation();
    int acc; bit ok;
    clear_logs(); busy_len = 5;
    force dut.jobs_done_q = 16'hFFFE;
    step();
    release dut.jobs_done_q;
    step();
    exp_jobs = 65534;
    total++; if (jobs_done !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%h want=fffe", jobs_done); end
    for (int i = 0; i < 3; i++) push_job(4'($urandom_range(0, 15)), 4'(i), acc, ok);
    wait_done(3, 200, ok);
    for (int i = 0; i < 3 && i < done_j.size(); i++) begin
      exp_jobs = (exp_jobs < 65535) ? exp_jobs + 1 : 65535;
      total++; if (done_j[i] !== 16'(exp_jobs)) begin bad++; $display("FAIL sat_count%0d got=%h want=%h", i, done_j[i], 16'(exp_jobs)); end
    end
    repeat (5) step();
    total++; if (!ok || jobs_done !== 16'hFFFF) begin bad++; $display("FAIL sat_final got=%h want=ffff", jobs_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stray_busy();
    test_random();
`ifdef CONV_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end
endmodule
